// File: rtl/tbl_port_arbiter_if.sv
// Bundle of the two table-client ports and the single-port table memory port
// seen by tbl_port_arbiter. The slave modport is the arbiter's view.
interface tbl_port_arbiter_if #(
    parameter int DW = 128,
    parameter int AW = 2
);
    logic          c0_rd_req;
    logic [AW-1:0] c0_rd_addr;
    logic          c0_rd_ack;
    logic [DW-1:0] c0_rd_data;
    logic          c0_wr_req;
    logic [AW-1:0] c0_wr_addr;
    logic [DW-1:0] c0_wr_data;
    logic          c0_wr_ack;

    logic          c1_rd_req;
    logic [AW-1:0] c1_rd_addr;
    logic          c1_rd_ack;
    logic [DW-1:0] c1_rd_data;
    logic          c1_wr_req;
    logic [AW-1:0] c1_wr_addr;
    logic [DW-1:0] c1_wr_data;
    logic          c1_wr_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  c0_rd_req, c0_rd_addr, c0_wr_req, c0_wr_addr, c0_wr_data,
        input  c1_rd_req, c1_rd_addr, c1_wr_req, c1_wr_addr, c1_wr_data,
        input  mem_rdata,
        output c0_rd_ack, c0_rd_data, c0_wr_ack,
        output c1_rd_ack, c1_rd_data, c1_wr_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output c0_rd_req, c0_rd_addr, c0_wr_req, c0_wr_addr, c0_wr_data,
        output c1_rd_req, c1_rd_addr, c1_wr_req, c1_wr_addr, c1_wr_data,
        output mem_rdata,
        input  c0_rd_ack, c0_rd_data, c0_wr_ack,
        input  c1_rd_ack, c1_rd_data, c1_wr_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/tbl_port_arbiter.sv
// Shares one single-port table memory between two table clients using a
// round-robin over four request lines, one operation in flight at a time.
module tbl_port_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_NUM_COLS       = 4,
    parameter int TBL_NUM_ROWS       = 4,
    parameter int RD_LATENCY         = 1
) (
    input  logic              Bus2IP_Clk,
    input  logic              Bus2IP_Reset,
    tbl_port_arbiter_if.slave bus
);
    localparam int DW = C_S_AXI_DATA_WIDTH * TBL_NUM_COLS;
    localparam int AW = (TBL_NUM_ROWS > 2) ? $clog2(TBL_NUM_ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [1:0]    rr_ptr_r, rr_ptr_nxt_s;
    logic [1:0]    src_r, src_nxt_s;
    logic [2:0]    lat_cnt_r, lat_cnt_nxt_s;
    logic          mem_en_r, mem_en_nxt_s;
    logic          mem_we_r, mem_we_nxt_s;
    logic [AW-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DW-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic          c0_rd_ack_r, c0_rd_ack_nxt_s;
    logic          c1_rd_ack_r, c1_rd_ack_nxt_s;
    logic          c0_wr_ack_r, c0_wr_ack_nxt_s;
    logic          c1_wr_ack_r, c1_wr_ack_nxt_s;
    logic [DW-1:0] c0_rd_data_r, c0_rd_data_nxt_s;
    logic [DW-1:0] c1_rd_data_r, c1_rd_data_nxt_s;
    logic          busy_r, busy_nxt_s;

    logic [3:0]    req_s;
    logic          grant_vld_s;
    logic [1:0]    grant_src_s;
    logic [1:0]    idx_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    // Rotating-priority search; descending scan so the lowest offset from rr_ptr wins
    always_comb begin
        req_s       = {bus.c1_rd_req, bus.c1_wr_req, bus.c0_rd_req, bus.c0_wr_req};
        grant_vld_s = 1'b0;
        grant_src_s = rr_ptr_r;
        idx_s       = rr_ptr_r;
        for (int i = 3; i >= 0; i--) begin
            idx_s       = rr_ptr_r + 2'(i);
            grant_src_s = req_s[idx_s] ? idx_s : grant_src_s;
            grant_vld_s = grant_vld_s | req_s[idx_s];
        end
    end

    // Address/data of the candidate winner, sampled only at grant
    always_comb begin
        sel_addr_s  = mem_addr_r;
        sel_wdata_s = mem_wdata_r;
        case (grant_src_s)
            2'd0: begin
                sel_addr_s  = bus.c0_wr_addr;
                sel_wdata_s = bus.c0_wr_data;
            end
            2'd1:    sel_addr_s = bus.c0_rd_addr;
            2'd2: begin
                sel_addr_s  = bus.c1_wr_addr;
                sel_wdata_s = bus.c1_wr_data;
            end
            2'd3:    sel_addr_s = bus.c1_rd_addr;
            default: sel_addr_s = mem_addr_r;
        endcase
    end

    // Next-state and next-output logic; outputs are registered alongside state
    always_comb begin
        state_nxt_s      = state_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        src_nxt_s        = src_r;
        lat_cnt_nxt_s    = lat_cnt_r;
        mem_en_nxt_s     = 1'b0;
        mem_we_nxt_s     = mem_we_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        c0_rd_ack_nxt_s  = 1'b0;
        c1_rd_ack_nxt_s  = 1'b0;
        c0_wr_ack_nxt_s  = 1'b0;
        c1_wr_ack_nxt_s  = 1'b0;
        c0_rd_data_nxt_s = c0_rd_data_r;
        c1_rd_data_nxt_s = c1_rd_data_r;
        case (state_r)
            S_IDLE: begin
                if (grant_vld_s) begin
                    src_nxt_s      = grant_src_s;
                    rr_ptr_nxt_s   = grant_src_s + 2'd1;
                    mem_en_nxt_s   = 1'b1;
                    mem_we_nxt_s   = ~grant_src_s[0];
                    mem_addr_nxt_s = sel_addr_s;
                    // Write data bus keeps its last write value across reads
                    mem_wdata_nxt_s = grant_src_s[0] ? mem_wdata_r : sel_wdata_s;
                    state_nxt_s    = S_ISSUE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!src_r[0]) begin
                    c0_wr_ack_nxt_s = (src_r == 2'd0);
                    c1_wr_ack_nxt_s = (src_r == 2'd2);
                    state_nxt_s     = S_ACK;
                end else begin
                    lat_cnt_nxt_s = 3'd1;
                    state_nxt_s   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt_r == 3'(RD_LATENCY)) begin
                    if (src_r[1]) begin
                        c1_rd_data_nxt_s = bus.mem_rdata;
                        c1_rd_ack_nxt_s  = 1'b1;
                    end else begin
                        c0_rd_data_nxt_s = bus.mem_rdata;
                        c0_rd_ack_nxt_s  = 1'b1;
                    end
                    state_nxt_s = S_ACK;
                end else begin
                    lat_cnt_nxt_s = lat_cnt_r + 3'd1;
                end
            end
            S_ACK:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
        busy_nxt_s = (state_nxt_s != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_r      <= S_IDLE;
            rr_ptr_r     <= 2'd0;
            src_r        <= 2'd0;
            lat_cnt_r    <= 3'd0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            c0_rd_ack_r  <= 1'b0;
            c1_rd_ack_r  <= 1'b0;
            c0_wr_ack_r  <= 1'b0;
            c1_wr_ack_r  <= 1'b0;
            c0_rd_data_r <= '0;
            c1_rd_data_r <= '0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
            src_r        <= src_nxt_s;
            lat_cnt_r    <= lat_cnt_nxt_s;
            mem_en_r     <= mem_en_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            c0_rd_ack_r  <= c0_rd_ack_nxt_s;
            c1_rd_ack_r  <= c1_rd_ack_nxt_s;
            c0_wr_ack_r  <= c0_wr_ack_nxt_s;
            c1_wr_ack_r  <= c1_wr_ack_nxt_s;
            c0_rd_data_r <= c0_rd_data_nxt_s;
            c1_rd_data_r <= c1_rd_data_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    assign bus.mem_en     = mem_en_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.c0_rd_ack  = c0_rd_ack_r;
    assign bus.c1_rd_ack  = c1_rd_ack_r;
    assign bus.c0_wr_ack  = c0_wr_ack_r;
    assign bus.c1_wr_ack  = c1_wr_ack_r;
    assign bus.c0_rd_data = c0_rd_data_r;
    assign bus.c1_rd_data = c1_rd_data_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_tbl_port_arbiter.sv
// Directed bench for tbl_port_arbiter: main instance at RD_LATENCY 1, plus
// instances at latency 2..4 for the latency sweep and the mid-read reset case.
module tb_tbl_port_arbiter;
    localparam int CW = 32;
    localparam int NC = 4;
    localparam int NR = 4;
    localparam int DW = CW * NC;
    localparam int AW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    // Unwritten rows of the memory model read back as this pattern
    function automatic logic [DW-1:0] row_init(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'hC0DE_0000 | {30'd0, a};
        return {w, w, w, w};
    endfunction

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    tbl_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    tbl_port_arbiter #(
        .C_S_AXI_DATA_WIDTH(CW), .TBL_NUM_COLS(NC), .TBL_NUM_ROWS(NR), .RD_LATENCY(1)
    ) u_dut (
        .Bus2IP_Clk  (clk),
        .Bus2IP_Reset(rst),
        .bus         (bus)
    );

    logic [DW-1:0] mem0 [NR];
    logic [NR-1:0] wr0 = '0;
    logic [DW-1:0] rd0 = '0;
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            mem0[bus.mem_addr] <= bus.mem_wdata;
            wr0[bus.mem_addr]  <= 1'b1;
        end
        rd0 <= wr0[bus.mem_addr] ? mem0[bus.mem_addr] : row_init(bus.mem_addr);
    end
    assign bus.mem_rdata = rd0;

    // Latency-sweep instances: index g runs at RD_LATENCY g+2
    int            sw_ack_n  [3];
    int            sw_en_cnt [3];
    logic [DW-1:0] sw_data   [3];
    int            sw_rs_nz  [3];
    int            sw_rs_ack [3];
    int            sw_rs_wr  [3];
    int            sw_done   [3];

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int L = g + 2;
        logic srst;
        tbl_port_arbiter_if #(.DW(DW), .AW(AW)) sbus ();
        tbl_port_arbiter #(
            .C_S_AXI_DATA_WIDTH(CW), .TBL_NUM_COLS(NC), .TBL_NUM_ROWS(NR), .RD_LATENCY(L)
        ) u_sw (
            .Bus2IP_Clk  (clk),
            .Bus2IP_Reset(srst),
            .bus         (sbus)
        );

        logic [DW-1:0] smem  [NR];
        logic [NR-1:0] swr = '0;
        logic [DW-1:0] spipe [4];
        always @(posedge clk) begin
            if (sbus.mem_en && sbus.mem_we) begin
                smem[sbus.mem_addr] <= sbus.mem_wdata;
                swr[sbus.mem_addr]  <= 1'b1;
            end
            spipe[0] <= swr[sbus.mem_addr] ? smem[sbus.mem_addr] : row_init(sbus.mem_addr);
            for (int k = 1; k < 4; k++) spipe[k] <= spipe[k-1];
        end
        assign sbus.mem_rdata = spipe[L-1];

        int ack_n, en_cnt, rs_nz, rs_ack, rs_wr, done;
        logic [DW-1:0] rdat;
        assign sw_ack_n[g]  = ack_n;
        assign sw_en_cnt[g] = en_cnt;
        assign sw_data[g]   = rdat;
        assign sw_rs_nz[g]  = rs_nz;
        assign sw_rs_ack[g] = rs_ack;
        assign sw_rs_wr[g]  = rs_wr;
        assign sw_done[g]   = done;

        initial begin
            ack_n = -1; en_cnt = 0; rs_nz = -1; rs_ack = 0; rs_wr = 0; done = 0; rdat = '0;
            sbus.c0_rd_req = 1'b0; sbus.c0_rd_addr = '0;
            sbus.c0_wr_req = 1'b0; sbus.c0_wr_addr = '0; sbus.c0_wr_data = '0;
            sbus.c1_rd_req = 1'b0; sbus.c1_rd_addr = '0;
            sbus.c1_wr_req = 1'b0; sbus.c1_wr_addr = '0; sbus.c1_wr_data = '0;
            srst = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            srst = 1'b0;
            sbus.c1_rd_addr = 2'd1;
            sbus.c1_rd_req  = 1'b1;
            for (int n = 1; n <= 30; n++) begin
                @(posedge clk); #1;
                if (sbus.mem_en) en_cnt++;
                if (sbus.c1_rd_ack) begin
                    ack_n = n;
                    rdat  = sbus.c1_rd_data;
                    sbus.c1_rd_req = 1'b0;
                    break;
                end
            end
            if (L == 3) begin
                @(negedge clk);
                @(negedge clk);
                sbus.c0_rd_addr = 2'd0;
                sbus.c0_rd_req  = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                srst = 1'b1;
                @(posedge clk); #1;
                rs_nz = (sbus.c0_rd_ack || sbus.c1_rd_ack || sbus.c0_wr_ack || sbus.c1_wr_ack ||
                         sbus.busy || sbus.mem_en || sbus.mem_we || sbus.mem_addr != '0 ||
                         sbus.mem_wdata != '0 || sbus.c0_rd_data != '0 ||
                         sbus.c1_rd_data != '0) ? 1 : 0;
                sbus.c0_rd_req = 1'b0;
                srst = 1'b0;
                repeat (6) begin
                    @(posedge clk); #1;
                    if (sbus.c0_rd_ack || sbus.c1_rd_ack || sbus.c0_wr_ack || sbus.c1_wr_ack)
                        rs_ack++;
                end
                @(negedge clk);
                sbus.c0_wr_addr = 2'd1;
                sbus.c0_wr_data = {4{32'h0000_5EED}};
                sbus.c0_wr_req  = 1'b1;
                sbus.c1_rd_addr = 2'd2;
                sbus.c1_rd_req  = 1'b1;
                @(posedge clk); #1;
                rs_wr = (sbus.mem_en && sbus.mem_we && sbus.mem_addr == 2'd1) ? 1 : 0;
                sbus.c1_rd_req = 1'b0;
                for (int n = 0; n < 10; n++) begin
                    @(posedge clk); #1;
                    if (sbus.c0_wr_ack) break;
                end
                sbus.c0_wr_req = 1'b0;
            end
            done = 1;
        end
    end

    task automatic drive_req(input int src, input logic v);
        case (src)
            0:       bus.c0_wr_req = v;
            1:       bus.c0_rd_req = v;
            2:       bus.c1_wr_req = v;
            3:       bus.c1_rd_req = v;
            default: ;
        endcase
    endtask

    function automatic logic ack_of(input int src);
        case (src)
            0:       ack_of = bus.c0_wr_ack;
            1:       ack_of = bus.c0_rd_ack;
            2:       ack_of = bus.c1_wr_ack;
            3:       ack_of = bus.c1_rd_ack;
            default: ack_of = 1'b0;
        endcase
    endfunction

    // Park at the negedge of an IDLE cycle so the next posedge is the grant edge
    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (bus.busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check_val("idle_wait", DW'(bus.busy), DW'(0));
    endtask

    task automatic run_op(input int src, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int ack_n, output int en_cnt, output int en_first);
        wait_idle();
        case (src)
            0: begin bus.c0_wr_addr = a; bus.c0_wr_data = d; end
            1: bus.c0_rd_addr = a;
            2: begin bus.c1_wr_addr = a; bus.c1_wr_data = d; end
            3: bus.c1_rd_addr = a;
            default: ;
        endcase
        drive_req(src, 1'b1);
        ack_n = -1; en_cnt = 0; en_first = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (bus.mem_en) begin
                en_cnt++;
                if (en_first < 0) en_first = n;
            end
            if (ack_of(src)) begin
                ack_n = n;
                drive_req(src, 1'b0);
                break;
            end
        end
    endtask

    localparam logic [DW-1:0] PAT_A5 = {16{8'hA5}};
    localparam logic [DW-1:0] PAT_D0 = {4{32'h0000_00D0}};
    localparam logic [DW-1:0] PAT_D3 = {4{32'h0000_00D3}};

    initial begin
        int an, ec, ef, ec_tot, k, lows, wt;
        int ord [6];
        int cyc [6];
        logic [DW-1:0] c1snap;

        bus.c0_rd_req = 1'b0; bus.c0_rd_addr = '0;
        bus.c0_wr_req = 1'b0; bus.c0_wr_addr = '0; bus.c0_wr_data = '0;
        bus.c1_rd_req = 1'b0; bus.c1_rd_addr = '0;
        bus.c1_wr_req = 1'b0; bus.c1_wr_addr = '0; bus.c1_wr_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_acks", DW'({bus.c0_rd_ack, bus.c1_rd_ack, bus.c0_wr_ack, bus.c1_wr_ack}), DW'(0));
        check_val("rst_mem_ctl", DW'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.busy}), DW'(0));
        check_val("rst_mem_wdata", bus.mem_wdata, '0);
        check_val("rst_rd_data", bus.c0_rd_data | bus.c1_rd_data, '0);
        @(negedge clk);
        rst = 1'b0;

        // Single write then read on client 0
        run_op(0, 2'd2, PAT_A5, an, ec, ef);
        ec_tot = ec;
        check_val("wr_ack_cycle", DW'(an), DW'(2));
        check_val("wr_en_cycle", DW'(ef), DW'(1));
        run_op(1, 2'd2, '0, an, ec, ef);
        ec_tot += ec;
        check_val("rd_ack_cycle", DW'(an), DW'(3));
        check_val("rd_en_cycle", DW'(ef), DW'(1));
        check_val("rd_data", bus.c0_rd_data, PAT_A5);
        check_val("en_pulses", DW'(ec_tot), DW'(2));

        // Full contention straight out of reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.c0_wr_addr = 2'd0; bus.c0_wr_data = PAT_D0;
        bus.c0_rd_addr = 2'd1;
        bus.c1_wr_addr = 2'd3; bus.c1_wr_data = PAT_D3;
        bus.c1_rd_addr = 2'd2;
        for (int s = 0; s < 4; s++) drive_req(s, 1'b1);
        k = 0; lows = 0; c1snap = '1;
        for (int n = 1; n <= 40 && k < 4; n++) begin
            @(posedge clk); #1;
            if (!bus.busy) lows++;
            for (int s = 0; s < 4; s++) begin
                if (ack_of(s)) begin
                    ord[k] = s;
                    cyc[k] = n;
                    if (s == 1) c1snap = bus.c1_rd_data;
                    drive_req(s, 1'b0);
                    k++;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("cont_order%0d", i), DW'(ord[i]), DW'(i));
        end
        check_val("cont_cyc0", DW'(cyc[0]), DW'(2));
        check_val("cont_cyc1", DW'(cyc[1]), DW'(6));
        check_val("cont_cyc2", DW'(cyc[2]), DW'(9));
        check_val("cont_cyc3", DW'(cyc[3]), DW'(13));
        check_val("cont_idle_gaps", DW'(lows), DW'(3));
        check_val("cont_c1_untouched", c1snap, '0);
        check_val("cont_c0_rd_data", bus.c0_rd_data, row_init(2'd1));
        check_val("cont_c1_rd_data", bus.c1_rd_data, PAT_A5);

        // Fairness: c0_rd held high continuously against c1_wr
        wait_idle();
        bus.c0_rd_addr = 2'd1;
        bus.c1_wr_addr = 2'd3; bus.c1_wr_data = PAT_D3 ^ {DW{1'b1}};
        bus.c0_rd_req = 1'b1;
        bus.c1_wr_req = 1'b1;
        k = 0;
        for (int n = 1; n <= 60 && k < 6; n++) begin
            @(posedge clk); #1;
            for (int s = 0; s < 4; s++) begin
                if (ack_of(s)) begin
                    ord[k] = s;
                    k++;
                end
            end
        end
        bus.c0_rd_req = 1'b0;
        bus.c1_wr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("fair_order%0d", i), DW'(ord[i]), DW'((i % 2 == 0) ? 1 : 2));
        end

        // Write data changed in the ISSUE cycle must not reach memory
        wait_idle();
        bus.c1_wr_addr = 2'd0;
        bus.c1_wr_data = {96'd0, 32'h1};
        bus.c1_wr_req  = 1'b1;
        @(posedge clk); #1;
        check_val("chg_issue_ctl", DW'({bus.mem_en, bus.mem_we, bus.mem_addr}), DW'({1'b1, 1'b1, 2'd0}));
        check_val("chg_wdata_col0", DW'(bus.mem_wdata[31:0]), DW'(32'h1));
        bus.c1_wr_data = {96'd0, 32'h2};
        wt = 0;
        while (!bus.c1_wr_ack && wt < 10) begin
            @(posedge clk); #1;
            wt++;
        end
        bus.c1_wr_req = 1'b0;
        check_val("chg_ack_cycle", DW'(wt + 1), DW'(2));
        check_val("chg_wdata_hold", {DW'(bus.mem_en), bus.mem_wdata}, {DW'(0), {96'd0, 32'h1}});
        run_op(3, 2'd0, '0, an, ec, ef);
        check_val("chg_readback", bus.c1_rd_data, {96'd0, 32'h1});

        // Latency sweep and mid-read reset from the side instances
        wt = 0;
        while ((sw_done[0] == 0 || sw_done[1] == 0 || sw_done[2] == 0) && wt < 2000) begin
            @(posedge clk);
            wt++;
        end
        for (int g = 0; g < 3; g++) begin
            check_val($sformatf("sweep_ack_L%0d", g + 2), DW'(sw_ack_n[g]), DW'(g + 4));
            check_val($sformatf("sweep_en_L%0d", g + 2), DW'(sw_en_cnt[g]), DW'(1));
            check_val($sformatf("sweep_data_L%0d", g + 2), sw_data[g], row_init(2'd1));
        end
        check_val("rst_mid_outputs", DW'(sw_rs_nz[1]), DW'(0));
        check_val("rst_mid_no_ack", DW'(sw_rs_ack[1]), DW'(0));
        check_val("rst_mid_rr_ptr", DW'(sw_rs_wr[1]), DW'(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
